// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, default width, negate helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [DIV_WIDTH-1:0] NEG(input logic [DIV_WIDTH-1:0] a);
        return ~a + DIV_WIDTH'(1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] y_mag,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH:0]   diff;

    // rem < |y| before each shift, so its top bit is always clear and nothing is lost here
    assign rem_sh = {rem[WIDTH-2:0], q[WIDTH-1]};
    assign diff   = {1'b0, rem_sh} - {1'b0, y_mag};

    always_comb begin
        rem_next = rem_sh;
        q_next   = {q[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            q_next   = {q[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/iter_div.sv
// Multicycle signed/unsigned restoring divider answering the ALU divide handshake.
// Latency: WIDTH+3 cycles from acceptance to the one-cycle div_complete pulse.
// Backpressure: requester holds div with stable operands; dropping div in BUSY/FIX aborts.
module iter_div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic             div_complete,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             sgn, sx, sy;
    logic [WIDTH-1:0] y_mag, q, rem;
    logic [WIDTH-1:0] q_nxt, rem_nxt;
    logic [WIDTH-1:0] x_mag_in, y_mag_in;
    logic             x_neg, y_neg, last_iter;

    assign x_neg     = div_signed & x[WIDTH-1];
    assign y_neg     = div_signed & y[WIDTH-1];
    assign x_mag_in  = x_neg ? NEG(x) : x;
    assign y_mag_in  = y_neg ? NEG(y) : y;
    assign last_iter = (cnt == CNT_W'(WIDTH-1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .q        (q),
        .y_mag    (y_mag),
        .rem_next (rem_nxt),
        .q_next   (q_nxt)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (div) state_nxt = BUSY;
            BUSY:    if (!div) state_nxt = IDLE;
                     else if (last_iter) state_nxt = FIX;
            FIX:     state_nxt = div ? DONE : IDLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign div_complete = (state == DONE);
    assign busy         = (state == BUSY) || (state == FIX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            sgn   <= 1'b0;
            sx    <= 1'b0;
            sy    <= 1'b0;
            y_mag <= '0;
            q     <= '0;
            rem   <= '0;
        end else if (state == IDLE && div) begin
            cnt   <= '0;
            sgn   <= div_signed;
            sx    <= x_neg;
            sy    <= y_neg;
            y_mag <= y_mag_in;
            q     <= x_mag_in;
            rem   <= '0;
        end else if (state == BUSY && div) begin
            cnt   <= cnt + CNT_W'(1);
            q     <= q_nxt;
            rem   <= rem_nxt;
        end
    end

    // results move only when FIX completes; an abort leaves the previous answer visible
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s <= '0;
            r <= '0;
        end else if (state == FIX && div) begin
            s <= (sgn && (sx ^ sy)) ? NEG(q) : q;
            r <= (sgn && sx) ? NEG(rem) : rem;
        end
    end

endmodule

// File: tb/tb_iter_div.sv
// Directed self-checking bench for iter_div: latency, signed/unsigned results, corners, b2b, abort, reset.
module tb_iter_div;

    logic        clk;
    logic        resetn;
    logic        div;
    logic        div_signed;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] s;
    logic [31:0] r;
    logic        div_complete;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    int pulses;

    iter_div dut (
        .clk          (clk),
        .resetn       (resetn),
        .div          (div),
        .div_signed   (div_signed),
        .x            (x),
        .y            (y),
        .s            (s),
        .r            (r),
        .div_complete (div_complete),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // counts negedges until div_complete is seen; -1 when the budget runs out
    task automatic wait_done(input int limit, output int l);
        int i;
        i = 0;
        l = -1;
        while (l < 0 && i < limit) begin
            @(negedge clk);
            i++;
            if (div_complete === 1'b1) l = i;
        end
    endtask

    task automatic start_op(input logic sg, input logic [31:0] xv, input logic [31:0] yv);
        div_signed = sg;
        x          = xv;
        y          = yv;
        div        = 1'b1;
    endtask

    task automatic run_op(input string tag, input logic sg, input logic [31:0] xv,
                          input logic [31:0] yv, input logic [31:0] s_exp, input logic [31:0] r_exp);
        int l;
        start_op(sg, xv, yv);
        wait_done(60, l);
        check({tag, "_lat"}, 32'(l), 32'd34);
        check({tag, "_s"}, s, s_exp);
        check({tag, "_r"}, r, r_exp);
        div = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        resetn     = 1'b0;
        div        = 1'b0;
        div_signed = 1'b0;
        x          = '0;
        y          = '0;
        repeat (3) @(negedge clk);
        check("rst_s", s, 32'd0);
        check("rst_r", r, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmp", 32'(div_complete), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // 100 / 7 unsigned, with pulse width and hold checks
        start_op(1'b0, 32'd100, 32'd7);
        @(negedge clk);
        check("u_busy", 32'(busy), 32'd1);
        wait_done(60, lat);
        check("u_lat", 32'(lat), 32'd33);
        check("u_s", s, 32'd14);
        check("u_r", r, 32'd2);
        check("u_busy_done", 32'(busy), 32'd0);
        div = 1'b0;
        @(negedge clk);
        check("u_pulse_end", 32'(div_complete), 32'd0);
        @(negedge clk);
        check("u_hold_s", s, 32'd14);
        check("u_hold_r", r, 32'd2);

        run_op("sneg_x", 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("sneg_y", 1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_op("s_ovf",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_op("u_max",  1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0);
        run_op("u_dz",   1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5);
        run_op("s_dz",   1'b1, 32'hFFFF_FFFB, 32'd0,         32'd1,         32'hFFFF_FFFB);
        run_op("u_big",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         32'd1);

        // back-to-back: second op presented in the DONE cycle, div never drops
        start_op(1'b0, 32'd100, 32'd7);
        wait_done(60, lat);
        check("b2b1_lat", 32'(lat), 32'd34);
        check("b2b1_s", s, 32'd14);
        x = 32'd9;
        y = 32'd3;
        wait_done(60, lat);
        check("b2b_gap", 32'(lat), 32'd35);
        check("b2b2_s", s, 32'd3);
        check("b2b2_r", r, 32'd0);
        div = 1'b0;
        @(negedge clk);

        // abort after 10 BUSY cycles
        start_op(1'b0, 32'd100, 32'd7);
        repeat (11) @(negedge clk);
        div    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_complete === 1'b1) pulses++;
        end
        check("abort_pulses", 32'(pulses), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_s", s, 32'd3);
        check("abort_r", r, 32'd0);
        run_op("post_abort", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);

        // asynchronous reset in the middle of BUSY
        start_op(1'b0, 32'd100, 32'd7);
        repeat (16) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        resetn = 1'b0;
        div    = 1'b0;
        #1;
        check("mid_rst_s", s, 32'd0);
        check("mid_rst_r", r, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cmp", 32'(div_complete), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        run_op("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_div.md
Name: iter_div

Overview:
- Multicycle radix-2 restoring divider. It is the responder side of the ALU's divide handshake.
- The ALU raises div with the operands and holds them stable until div_complete. The block returns the quotient (s) and remainder (r) for the signed ops (div.w/mod.w) and unsigned ops (div.wu/mod.wu).
- It sits inside the EX-stage ALU. The pipeline stalls until div_complete.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is verified.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  core clock, rising edge
- resetn  input  1  asynchronous active-low reset
- div  input  1  request level from ALU. Held high with stable operands until div_complete.
- div_signed  input  1  1 = two's-complement ops, 0 = unsigned. Sampled at acceptance.
- x  input  WIDTH  dividend
- y  input  WIDTH  divisor
- s  output  WIDTH  quotient, registered
- r  output  WIDTH  remainder, registered
- div_complete  output  1  one-cycle pulse; s/r valid in this cycle
- busy  output  1  high in BUSY and FIX states

Behaviour:
- Reset (resetn low, async): state=IDLE, cnt=0, s=0, r=0, div_complete=0, busy=0. All internal working registers are cleared.
- States are IDLE, BUSY, FIX, DONE.
- IDLE:
  - If div=1, accept. Latch div_signed, the sign bits of x and y, and the magnitudes |x| and |y|. Magnitude is the operand itself when unsigned or non-negative, the two's complement otherwise.
  - Set quotient/dividend shift register to |x|, partial remainder to 0, cnt=0. Go to BUSY.
- BUSY, one quotient bit per cycle:
  - rem' = {rem[WIDTH-2:0], q[WIDTH-1]}.
  - diff = rem' - |y|, computed WIDTH+1 bits wide.
  - If diff >= 0: rem=diff[WIDTH-1:0] and shift 1 into q. Else rem=rem' and shift 0 into q.
  - cnt++. After the WIDTH-th iteration (cnt==WIDTH-1 at the edge), go to FIX.
- FIX:
  - Quotient sign = sx^sy; remainder sign = sx. Signed only; in unsigned mode no negation.
  - Load s and r with the sign-corrected values. Go to DONE.
- DONE:
  - div_complete=1 for exactly this cycle. s/r hold.
  - Next state is always IDLE. A back-to-back div is accepted in IDLE the following cycle, which samples the new instruction's operands.
- Latency: acceptance edge at T; complete asserted during cycle T+WIDTH+2 (34 for WIDTH=32). Throughput is one op per WIDTH+3 cycles.
- s/r change only on the FIX→DONE edge and on reset. They hold their values otherwise, including across aborts.
- Abort: div=0 while in BUSY or FIX → IDLE next edge. No complete pulse; s/r unchanged. This covers pipeline flush and exceptions.
- Divide by zero (|y|=0) follows the natural datapath, deterministic with no trap:
  - unsigned: s=0xFFFFFFFF, r=x
  - signed: quotient all-ones magnitude is sign-corrected, so x>=0 → s=0xFFFFFFFF, x<0 → s=0x00000001; r=x
- Overflow: x=0x80000000, y=0xFFFFFFFF, signed → s=0x80000000, r=0. No flag.
- Magnitude of 0x80000000 is 0x80000000 as unsigned. No special case is needed.
- div_signed, x and y changing mid-operation are ignored; only the latched values are used.
- busy=0 in IDLE and DONE.

Decomposition:
- Shared package (div_pkg) holds:
  - state encoding: IDLE=2'd0, BUSY=2'd1, FIX=2'd2, DONE=2'd3
  - WIDTH default
  - a NEG(a) helper function returning two's complement
- One sub-module is natural: div_step. It is a combinational one-iteration restoring step with inputs rem, q, |y| and outputs rem_next, q_next.
- The FSM, counter and sign-fix logic stay in iter_div.

Test Plan:
- Unsigned: x=100, y=7, div_signed=0 → after 34 cycles div_complete=1, s=14, r=2. Pulse lasts 1 cycle; s/r hold afterwards.
- Signed mixed signs: x=-7 (0xFFFFFFF9), y=2, signed → s=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Also x=7, y=-2 → s=-3, r=1.
- Corner cases:
  - signed 0x80000000/0xFFFFFFFF → s=0x80000000, r=0
  - unsigned 0xFFFFFFFF/1 → s=0xFFFFFFFF, r=0
  - unsigned y=0, x=5 → s=0xFFFFFFFF, r=5
- Back-to-back: keep div=1 across two ops (100/7, then 9/3 presented in the DONE cycle) → two pulses 35 cycles apart; second result s=3, r=0.
- Abort: drop div at cycle 10 of BUSY → no div_complete within 40 cycles; s/r retain the previous values. A new request then completes normally.
- Reset mid-op: pull resetn low at cycle 15 of BUSY (asynchronously, between edges) → s=0, r=0, busy=0 immediately, state IDLE. After release, 100/7 completes correctly.
